// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      divOp,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   ITERS   = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [XLEN-1:0] rem_reg, rem_next;
    logic [XLEN-1:0] quo_reg, quo_next;
    logic [XLEN-1:0] dvs_reg, dvs_next;
    logic [XLEN-1:0] dvd_reg, dvd_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            is_rem_reg, is_rem_next;
    logic            neg_quo_reg, neg_quo_next;
    logic            neg_rem_reg, neg_rem_next;
    logic            div0_reg, div0_next;
    logic            ovf_reg, ovf_next;

    // Operand decode at accept time
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic            in_div0;
    logic            in_ovf;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    assign signed_op = ~divOp[0];
    assign a_neg     = signed_op & dividend[XLEN-1];
    assign b_neg     = signed_op & divisor[XLEN-1];
    assign a_mag     = a_neg ? -dividend : dividend;
    assign b_mag     = b_neg ? -divisor : divisor;
    assign in_div0   = (divisor == '0);
    assign in_ovf    = signed_op & (dividend == MIN_NEG) & (divisor == '1);

    // One restoring step: shift the next dividend bit into the partial remainder
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            borrow;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;

    assign shifted  = {rem_reg, quo_reg[XLEN-1]};
    assign diff     = {1'b0, shifted} - {2'b00, dvs_reg};
    assign borrow   = diff[XLEN+1];
    // On borrow, shifted < divisor < 2^XLEN, so dropping its top bit is lossless
    assign rem_step = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_step = {quo_reg[XLEN-2:0], ~borrow};

    function automatic logic [XLEN-1:0] special_value(
        input logic            rem_op,
        input logic            zero_div,
        input logic [XLEN-1:0] dvd
    );
        if (zero_div)
            return rem_op ? dvd : '1;
        return rem_op ? '0 : MIN_NEG;
    endfunction

    logic [XLEN-1:0] fin_quo;
    logic [XLEN-1:0] fin_rem;
    logic [XLEN-1:0] final_value;

    assign fin_quo     = neg_quo_reg ? -quo_step : quo_step;
    assign fin_rem     = neg_rem_reg ? -rem_step : rem_step;
    assign final_value = (div0_reg | ovf_reg) ? special_value(is_rem_reg, div0_reg, dvd_reg)
                                              : (is_rem_reg ? fin_rem : fin_quo);

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        dvs_next     = dvs_reg;
        dvd_next     = dvd_reg;
        result_next  = result_reg;
        is_rem_next  = is_rem_reg;
        neg_quo_next = neg_quo_reg;
        neg_rem_next = neg_rem_reg;
        div0_next    = div0_reg;
        ovf_next     = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (start && !flush) begin
                    dvd_next     = dividend;
                    dvs_next     = b_mag;
                    quo_next     = a_mag;
                    rem_next     = '0;
                    count_next   = ITERS;
                    is_rem_next  = divOp[1];
                    neg_quo_next = (a_neg ^ b_neg) & ~in_div0;
                    neg_rem_next = a_neg;
                    div0_next    = in_div0;
                    ovf_next     = in_ovf;
                    state_next   = RUN;
`ifdef DIV_EARLY_OUT_EN
                    if (in_div0 || in_ovf) begin
                        count_next  = '0;
                        result_next = special_value(divOp[1], in_div0, dividend);
                        state_next  = DONE;
                    end
`else
                    // Special cases still run the full iteration; result is overridden at the end
`endif
                end
            end
            RUN: begin
                if (flush) begin
                    count_next = '0;
                    state_next = IDLE;
                end else begin
                    rem_next   = rem_step;
                    quo_next   = quo_step;
                    count_next = count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        result_next = final_value;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            dvd_reg     <= '0;
            result_reg  <= '0;
            is_rem_reg  <= 1'b0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            dvs_reg     <= dvs_next;
            dvd_reg     <= dvd_next;
            result_reg  <= result_next;
            is_rem_reg  <= is_rem_next;
            neg_quo_reg <= neg_quo_next;
            neg_rem_reg <= neg_rem_next;
            div0_reg    <= div0_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign busy   = (state_reg != IDLE);
    // A flush during the DONE cycle kills the pulse so the pipeline never writes back a squashed op
    assign done   = (state_reg == DONE) && !flush;
    assign result = result_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus random ops against an arithmetic reference.
// Latency convention: done is visible XLEN edges after the accept edge (sampled at the 33rd), or 0 for early-out.
module tb_div_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [1:0]      divOp = 2'b00;
    logic [XLEN-1:0] dividend = '0;
    logic [XLEN-1:0] divisor = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = 32'h0;

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .flush    (flush),
        .divOp    (divOp),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Reference: RISC-V M-extension semantics using plain SV arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        if (!op[0])
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 0;
`endif
        return XLEN;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Wait for done after an accept edge; returns edges counted and whether busy ever dropped
    task automatic wait_done(output int cnt, output logic busy_low);
        cnt = 0;
        busy_low = 1'b0;
        while (!done && cnt < 200) begin
            if (!busy) busy_low = 1'b1;
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    // Called #1 after a posedge with the DUT idle
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          cnt;
        logic        busy_low;
        exp     = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        divOp = op; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom; divOp = 2'($urandom);
        wait_done(cnt, busy_low);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, cnt, exp_lat);
        check({tag, "_busy"}, 32'(busy_low), 32'd0);
        check({tag, "_res"}, result, exp);
        $display("op=%0d a=0x%08h b=0x%08h result=0x%08h exp=0x%08h lat=%0d tag=%s",
                 op, a, b, result, exp, cnt, tag);
        last_exp = exp;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          cnt;
        logic        busy_low;
        logic        seen_done;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset with start asserted
        start = 1'b1; divOp = 2'b01; dividend = 32'd100; divisor = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        start = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_noaccept", 32'(busy), 32'd0);
        $display("reset: busy=%0b done=%0b result=0x%08h", busy, done, result);

        do_op(2'b01, 32'd100, 32'd7, "divu_100_7");
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, "remu_big_2");
        do_op(2'b00, 32'd5, 32'd0, "div_5_0");
        do_op(2'b10, 32'd5, 32'd0, "rem_5_0");
        do_op(2'b01, 32'hDEAD_BEEF, 32'd0, "divu_x_0");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        do_op(2'b00, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");

        // Flush during RUN cycle 10: no done, result unchanged
        divOp = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_run_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", 32'(busy), 32'd0);
        check("flush_result", result, last_exp);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("flush_no_done", 32'(seen_done), 32'd0);
        $display("flush in RUN: busy=%0b result=0x%08h", busy, result);
        do_op(2'b01, 32'd9, 32'd3, "divu_9_3");

        // flush together with start in IDLE: no accept
        divOp = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", 32'(busy), 32'd0);
        $display("flush+start in IDLE: busy=%0b", busy);

        // Flush during the DONE cycle: done suppressed, back to IDLE
        divOp = 2'b01; dividend = 32'd77; divisor = 32'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (XLEN) @(posedge clk);
        #1;
        check("done_state_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        check("flush_done_pulse", 32'(done), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done_idle", 32'(busy), 32'd0);
        $display("flush in DONE: busy=%0b", busy);
        last_exp = 32'd7;

        // Start pulsed during RUN is ignored
        divOp = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        divOp = 2'b00; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cnt, busy_low);
        check("midstart_done", 32'(done), 32'd1);
        check("midstart_lat", cnt, XLEN - 6);
        check("midstart_res", result, 32'd14);
        @(posedge clk); #1;
        check("midstart_noqueue", 32'(busy), 32'd0);
        $display("start during RUN: result=0x%08h lat_rest=%0d", result, cnt);

        // Back-to-back with start held high
        divOp = 2'b01; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        divOp = 2'b00; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
        wait_done(cnt, busy_low);
        check("b2b_a_done", 32'(done), 32'd1);
        check("b2b_a_res", result, 32'd100);
        @(posedge clk); #1;
        check("b2b_gap_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("b2b_b_accept", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(cnt, busy_low);
        check("b2b_b_done", 32'(done), 32'd1);
        check("b2b_b_lat", cnt, XLEN);
        check("b2b_b_res", result, 32'hFFFF_FFF2);
        $display("back-to-back: second result=0x%08h lat=%0d", result, cnt);
        @(posedge clk); #1;

        // Random operations against the reference
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin b = $urandom; a = a >> $urandom_range(0, 31); end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(op, a, b, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
